// File: rtl/bcd_score_display.sv
// bcd_score_display: N-digit BCD score counter with registered 7-segment decode.
// Segments are active-low and ordered {A,B,C,D,E,F,G} within each 7-bit slice.
// Optional feature macro: HIGH_SCORE_EN adds a high-score register and the
// HS_SEG port. Without it the high-score register and HS_SEG do not exist.
module bcd_score_display #(
  parameter int DIGITS   = 2,
  parameter int SATURATE = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  INC,
  input  logic                  CLR,
  output logic [7*DIGITS-1:0]   SEG,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  MAXED
`ifdef HIGH_SCORE_EN
  ,
  output logic [7*DIGITS-1:0]   HS_SEG
`endif
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [7*DIGITS-1:0] SEG_ZEROS = {DIGITS{7'b0000001}};

  logic                 inc_q;
  logic                 inc_ev;
  logic                 carry;
  logic [4*DIGITS-1:0]  count_inc;
  logic [4*DIGITS-1:0]  count_nxt;
  logic [7*DIGITS-1:0]  seg_dec;

  // BCD digit to active-low {A,B,C,D,E,F,G}
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign inc_ev = INC & ~inc_q;

  // Ripple the +1 through the digits: a digit advances only while every lower digit was 9
  always_comb begin
    count_inc = COUNT;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (COUNT[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = COUNT[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Next count: clear wins, then increment event; all-9s either holds or wraps to 0
  always_comb begin
    count_nxt = COUNT;
    if (CLR) begin
      count_nxt = '0;
    end else if (inc_ev) begin
      if ((COUNT == ALL_NINES) && (SATURATE != 0)) begin
        count_nxt = COUNT;
      end else begin
        count_nxt = count_inc;
      end
    end
  end

  // Per-digit decode of the current count
  always_comb begin
    seg_dec = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      seg_dec[7*i +: 7] = seg_decode(COUNT[4*i +: 4]);
    end
  end

  // Count, edge-detect history and MAXED flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inc_q <= 1'b0;
      COUNT <= '0;
      MAXED <= 1'b0;
    end else begin
      inc_q <= INC;
      COUNT <= count_nxt;
      MAXED <= (count_nxt == ALL_NINES);
    end
  end

  // Segment outputs trail COUNT by one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG <= SEG_ZEROS;
    end else begin
      SEG <= seg_dec;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [4*DIGITS-1:0] hs_q;
  logic [7*DIGITS-1:0] hs_dec;

  // Per-digit decode of the high score
  always_comb begin
    hs_dec = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      hs_dec[7*i +: 7] = seg_decode(hs_q[4*i +: 4]);
    end
  end

  // High score captures the pre-clear count; packed BCD compares correctly as binary
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_q <= '0;
    end else if (CLR && (COUNT > hs_q)) begin
      hs_q <= COUNT;
    end
  end

  // High-score segments trail hs by one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      HS_SEG <= SEG_ZEROS;
    end else begin
      HS_SEG <= hs_dec;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_score_display.sv
// Bench for bcd_score_display: a saturating and a wrapping instance share the
// same stimulus and are checked against an integer-valued score model.
`timescale 1ns/100ps
module tb_bcd_score_display;

  localparam int DIGITS = 2;
  localparam int MAXV   = 99;

  logic clk;
  logic rst_n;
  logic inc;
  logic clr;

  logic [7*DIGITS-1:0] s_seg, w_seg;
  logic [4*DIGITS-1:0] s_count, w_count;
  logic                s_maxed, w_maxed;
`ifdef HIGH_SCORE_EN
  logic [7*DIGITS-1:0] s_hs_seg, w_hs_seg;
`endif

  int checks   = 0;
  int failures = 0;

  // model state, index 0 = saturating instance, 1 = wrapping instance
  int m_cnt   [2];
  int m_incq  [2];
  int m_hs    [2];
  int m_segv  [2];
  int m_hssegv[2];

  logic [6:0] seg_tab [10];

  bcd_score_display #(.DIGITS(DIGITS), .SATURATE(1)) u_sat (
    .CLK    (clk),
    .RST_N  (rst_n),
    .INC    (inc),
    .CLR    (clr),
    .SEG    (s_seg),
    .COUNT  (s_count),
    .MAXED  (s_maxed)
`ifdef HIGH_SCORE_EN
    ,
    .HS_SEG (s_hs_seg)
`endif
  );

  bcd_score_display #(.DIGITS(DIGITS), .SATURATE(0)) u_wrap (
    .CLK    (clk),
    .RST_N  (rst_n),
    .INC    (inc),
    .CLR    (clr),
    .SEG    (w_seg),
    .COUNT  (w_count),
    .MAXED  (w_maxed)
`ifdef HIGH_SCORE_EN
    ,
    .HS_SEG (w_hs_seg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int v);
    logic [63:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] to_seg(input int v);
    logic [63:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = seg_tab[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_incq[s] = 0; m_hs[s] = 0; m_segv[s] = 0; m_hssegv[s] = 0;
    end
  endtask

  // one clock edge of the score rules, both instances
  task automatic model_edge(input logic i, input logic c);
    int old_cnt, old_hs;
    for (int s = 0; s < 2; s++) begin
      old_cnt = m_cnt[s];
      old_hs  = m_hs[s];
      if (c) begin
        if (m_cnt[s] > m_hs[s]) m_hs[s] = m_cnt[s];
        m_cnt[s] = 0;
      end else if (i && (m_incq[s] == 0)) begin
        if (m_cnt[s] == MAXV) m_cnt[s] = (s == 0) ? MAXV : 0;
        else                  m_cnt[s] = m_cnt[s] + 1;
      end
      m_incq[s]   = i ? 1 : 0;
      m_segv[s]   = old_cnt;
      m_hssegv[s] = old_hs;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".sat.count"}, 64'(s_count), to_bcd(m_cnt[0]));
    check({tag, ".sat.maxed"}, 64'(s_maxed), 64'(m_cnt[0] == MAXV));
    check({tag, ".sat.seg"},   64'(s_seg),   to_seg(m_segv[0]));
    check({tag, ".wrp.count"}, 64'(w_count), to_bcd(m_cnt[1]));
    check({tag, ".wrp.maxed"}, 64'(w_maxed), 64'(m_cnt[1] == MAXV));
    check({tag, ".wrp.seg"},   64'(w_seg),   to_seg(m_segv[1]));
`ifdef HIGH_SCORE_EN
    check({tag, ".sat.hs_seg"}, 64'(s_hs_seg), to_seg(m_hssegv[0]));
    check({tag, ".wrp.hs_seg"}, 64'(w_hs_seg), to_seg(m_hssegv[1]));
`endif
  endtask

  task automatic step(input logic i, input logic c, input string tag);
    @(negedge clk);
    inc = i;
    clr = c;
    @(posedge clk);
    #1;
    model_edge(i, c);
    compare_all(tag);
  endtask

  task automatic pulses(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, tag);
      step(1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;

    rst_n = 1'b0; inc = 1'b0; clr = 1'b0;
    reset_model();
    #12;
    compare_all("in_reset");
    rst_n = 1'b1;

    // reset release with INC low
    step(1'b0, 1'b0, "rst_idle");
    check("rst_seg_const", 64'(s_seg), 64'(14'b0000001_0000001));

    // held INC counts once; SEG follows one edge later
    step(1'b1, 1'b0, "hold_first");
    check("hold_seg_lag", 64'(s_seg[6:0]), 64'(7'b0000001));
    step(1'b1, 1'b0, "hold_next");
    check("hold_seg_one", 64'(s_seg[6:0]), 64'(7'b1001111));
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, "hold");
    step(1'b0, 1'b0, "hold_rel");
    check("hold_once", 64'(s_count), 64'(8'h01));

    // ten separated pulses from 0
    step(1'b0, 1'b1, "clr_a");
    pulses(10, "ten");
    check("ten_count", 64'(s_count), 64'(8'h10));
    check("ten_seg", 64'(s_seg), 64'(14'b1001111_0000001));

    // saturate / wrap boundary from 98
    step(1'b0, 1'b1, "clr_b");
    pulses(98, "to98");
    step(1'b1, 1'b0, "p99");
    check("wrap_99", 64'(w_count), 64'(8'h99));
    check("wrap_99_maxed", 64'(w_maxed), 64'(1));
    step(1'b0, 1'b0, "p99_low");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "p_hold");
    check("sat_hold", 64'(s_count), 64'(8'h99));
    check("sat_maxed", 64'(s_maxed), 64'(1));
    check("wrap_zero", 64'(w_count), 64'(8'h00));
    check("wrap_maxed0", 64'(w_maxed), 64'(0));

    // CLR and INC rise together at 42; held INC must not recount
    step(1'b0, 1'b1, "clr_c");
    pulses(42, "to42");
    check("at42", 64'(s_count), 64'(8'h42));
    step(1'b1, 1'b1, "clr_inc");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "clr_hold");
    check("clr_hold_zero", 64'(s_count), 64'(8'h00));
    step(1'b0, 1'b0, "clr_rel");

    // high score: 37, clear, 25, clear
    pulses(37, "to37");
    step(1'b0, 1'b1, "hs_clr1");
    step(1'b0, 1'b0, "hs_wait1");
`ifdef HIGH_SCORE_EN
    check("hs_37_a", 64'(s_hs_seg), 64'(14'b0000110_0001111));
`endif
    pulses(25, "to25");
    step(1'b0, 1'b1, "hs_clr2");
    step(1'b0, 1'b0, "hs_wait2");
`ifdef HIGH_SCORE_EN
    check("hs_37_b", 64'(s_hs_seg), 64'(14'b0000110_0001111));
`endif

    // asynchronous reset mid-cycle with a nonzero count
    pulses(5, "pre_rst");
    #1;
    rst_n = 1'b0;
    #1;
    reset_model();
    compare_all("async_rst");
    rst_n = 1'b1;

    // randomized traffic, starting near the top so both boundaries are exercised
    pulses(96, "to96");
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
